// File: rtl/stream_delay_arb_pkg.sv
// Shared types and helpers for the stream delay arbiter.
// Optional statistics counters are enabled with STREAM_DELAY_ARB_STATS_EN.
package stream_delay_arb_pkg;

    // Arbiter FSM states; the encoding is fixed so waveforms read consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SEND  = 2'd2
    } state_e;

    // Index width for n items; never below one bit so a single requester still
    // gets a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_delay_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping back to index 0 when nothing above the pointer is set.
module stream_delay_arb_rr_pick #(
    parameter int NumReq   = 4,
    parameter int IdxWidth = 2
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic                any_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [NumReq-1:0] upper_req;
    logic [NumReq-1:0] search_req;

    // Requests at or above the pointer win over the wrapped-around ones.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_upper
        assign upper_req[gi] = req_i[gi] && (gi >= int'(ptr_i));
    end

    assign any_o = |req_i;

    // Lowest set bit of the chosen search vector.
    always_comb begin
        search_req = (|upper_req) ? upper_req : req_i;
        idx_o      = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (search_req[i]) begin
                idx_o = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/stream_delay_arbiter.sv
// Round-robin arbiter that serialises NumReq streams onto one output, inserting
// a per-grant programmable delay before presenting the payload downstream.
// Define STREAM_DELAY_ARB_STATS_EN to add per-requester handshake counters.
module stream_delay_arbiter
    import stream_delay_arb_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int DataWidth  = 32,
    parameter int DelayWidth = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                valid_i,
    output logic [NumReq-1:0]                ready_o,
    input  logic [NumReq*DataWidth-1:0]      payload_i,
    input  logic [DelayWidth-1:0]            delay_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DataWidth-1:0]             payload_o,
`ifdef STREAM_DELAY_ARB_STATS_EN
    output logic [NumReq*16-1:0]             xfer_cnt_o,
`endif
    output logic [clog2_min1(NumReq)-1:0]    idx_o,
    output logic                             busy_o
);

    localparam int IdxWidth = clog2_min1(NumReq);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

    state_e                state_reg, state_next;
    logic [IdxWidth-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IdxWidth-1:0]   grant_idx_reg, grant_idx_next;
    logic [DelayWidth-1:0] count_reg, count_next;

    logic                  pick_any;
    logic [IdxWidth-1:0]   pick_idx;
    logic [DataWidth-1:0]  payload_arr [NumReq];

    stream_delay_arb_rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .req_i (valid_i),
        .ptr_i (rr_ptr_reg),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // State, pointer, grant and countdown registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_idx_reg <= grant_idx_next;
            count_reg     <= count_next;
        end
    end

    // Next-state logic: grant in IDLE, count down in DELAY, wait for ready in SEND.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_idx_next = grant_idx_reg;
        count_next     = count_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_idx_next = pick_idx;
                    count_next     = delay_i;
                    state_next     = (delay_i != '0) ? DELAY : SEND;
                end
            end
            DELAY: begin
                count_next = count_reg - 1'b1;
                if (count_reg == DelayWidth'(1)) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    rr_ptr_next = (grant_idx_reg == LastIdx) ? '0 : grant_idx_reg + 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Unpack the flat payload bus so the granted lane can be selected by index.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_payload
        assign payload_arr[gi] = payload_i[gi*DataWidth +: DataWidth];
    end

    // Only the granted requester sees downstream ready, and only while sending.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
        assign ready_o[gi] = (state_reg == SEND) && ready_i && (grant_idx_reg == IdxWidth'(gi));
    end

    assign valid_o   = (state_reg == SEND);
    assign busy_o    = (state_reg != IDLE);
    assign idx_o     = grant_idx_reg;
    assign payload_o = payload_arr[grant_idx_reg];

`ifdef STREAM_DELAY_ARB_STATS_EN
    // Saturating handshake counter per requester.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_stats
        logic [15:0] cnt_reg;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
            end else if (ready_o[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
        assign xfer_cnt_o[gi*16 +: 16] = cnt_reg;
    end
`endif

`ifndef SYNTHESIS
    // A granted requester must keep valid asserted until its handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_reg != IDLE)) begin
            assert (valid_i[grant_idx_reg])
                else $error("granted requester dropped valid before handshake");
        end
    end
`endif

endmodule

// File: tb/tb_stream_delay_arbiter.sv
// Self-checking bench for stream_delay_arbiter: vector table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_stream_delay_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int LW = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     valid_i;
    logic [NR-1:0]     ready_o;
    logic [NR*DW-1:0]  payload_i;
    logic [LW-1:0]     delay_i;
    logic              valid_o;
    logic              ready_i;
    logic [DW-1:0]     payload_o;
    logic [1:0]        idx_o;
    logic              busy_o;

    // Single-requester instance for the NumReq=1 boundary.
    logic              v1;
    logic [0:0]        r1o;
    logic [DW-1:0]     p1;
    logic [LW-1:0]     d1;
    logic              vo1;
    logic              ri1;
    logic [DW-1:0]     po1;
    logic [0:0]        i1;
    logic              b1;

`ifdef STREAM_DELAY_ARB_STATS_EN
    logic [NR*16-1:0]  xfer_cnt_o;
    logic [15:0]       xfer_cnt1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    stream_delay_arbiter #(.NumReq(NR), .DataWidth(DW), .DelayWidth(LW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .payload_i (payload_i),
        .delay_i   (delay_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .payload_o (payload_o),
`ifdef STREAM_DELAY_ARB_STATS_EN
        .xfer_cnt_o(xfer_cnt_o),
`endif
        .idx_o     (idx_o),
        .busy_o    (busy_o)
    );

    stream_delay_arbiter #(.NumReq(1), .DataWidth(DW), .DelayWidth(LW)) dut1 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (v1),
        .ready_o   (r1o),
        .payload_i (p1),
        .delay_i   (d1),
        .valid_o   (vo1),
        .ready_i   (ri1),
        .payload_o (po1),
`ifdef STREAM_DELAY_ARB_STATS_EN
        .xfer_cnt_o(xfer_cnt1),
`endif
        .idx_o     (i1),
        .busy_o    (b1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = '0;
        ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_idx", idx_o, 0);
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        logic [LW-1:0] dly;
        int            stall;
        int            exp_idx;
        logic [DW-1:0] pay;
    } vec_t;

    vec_t tbl [7];

    // Reference model state for the randomized run.
    logic          pend   [NR];
    logic [DW-1:0] pay_q  [NR];
    bit            m_busy;
    int            m_wait;
    int            m_gidx;
    int            m_ptr;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; valid_i = '0; payload_i = '0; delay_i = '0; ready_i = 1'b0;
        v1 = 1'b0; p1 = '0; d1 = '0; ri1 = 1'b0;

        tbl[0] = '{4'b0100, 4'd0,  0, 2, 32'h0000_00A5};
        tbl[1] = '{4'b0001, 4'd3,  0, 0, 32'h1111_2222};
        tbl[2] = '{4'b1010, 4'd1,  2, 1, 32'hDEAD_BEEF};
        tbl[3] = '{4'b1000, 4'd15, 0, 3, 32'hCAFE_F00D};
        tbl[4] = '{4'b1100, 4'd2,  5, 2, 32'h0BAD_C0DE};
        tbl[5] = '{4'b0001, 4'd0,  5, 0, 32'h5555_AAAA};
        tbl[6] = '{4'b1111, 4'd4,  1, 0, 32'h0123_4567};

        // Table-driven single transactions from a fresh reset (rr_ptr = 0).
        for (int v = 0; v < 7; v++) begin
            do_reset();
            valid_i = tbl[v].mask;
            delay_i = tbl[v].dly;
            ready_i = (tbl[v].stall == 0);
            for (int k = 0; k < NR; k++)
                payload_i[k*DW +: DW] = (k == tbl[v].exp_idx) ? tbl[v].pay : $urandom;
            #1;
            chk("vec_idle_valid", valid_o, 0);
            chk("vec_idle_ready", ready_o, 0);
            step();
            delay_i = LW'($urandom);
            for (int c = 1; c <= int'(tbl[v].dly); c++) begin
                #1;
                chk("vec_dly_valid", valid_o, 0);
                chk("vec_dly_ready", ready_o, 0);
                chk("vec_dly_busy", busy_o, 1);
                step();
            end
            #1;
            chk("vec_send_valid", valid_o, 1);
            chk("vec_send_idx", idx_o, tbl[v].exp_idx);
            chk("vec_send_pay", payload_o, tbl[v].pay);
            for (int s = 0; s < tbl[v].stall; s++) begin
                chk("vec_stall_ready", ready_o, 0);
                chk("vec_stall_valid", valid_o, 1);
                chk("vec_stall_idx", idx_o, tbl[v].exp_idx);
                chk("vec_stall_pay", payload_o, tbl[v].pay);
                step();
                #1;
            end
            ready_i = 1'b1;
            #1;
            chk("vec_hs_ready", ready_o, 64'(1) << tbl[v].exp_idx);
            step();
            valid_i = '0;
            #1;
            chk("vec_after_busy", busy_o, 0);
            chk("vec_after_valid", valid_o, 0);
        end

        // Round-robin order with all requesters asserting continuously.
        do_reset();
        valid_i = 4'b1111; delay_i = '0; ready_i = 1'b1;
        for (int k = 0; k < NR; k++) payload_i[k*DW +: DW] = 32'hF000_0000 + k;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("rr_idle_valid", valid_o, 0);
            step();
            #1;
            chk("rr_valid", valid_o, 1);
            chk("rr_idx", idx_o, t % NR);
            chk("rr_pay", payload_o, 32'hF000_0000 + (t % NR));
            step();
        end
        valid_i = '0;

        // Reset during the third DELAY cycle aborts and clears the pointer.
        do_reset();
        valid_i = 4'b0001; delay_i = '0; ready_i = 1'b1;
        step(); step();                   // requester 0 served, pointer now 1
        valid_i = 4'b0011; delay_i = 4'd7;
        step(); step(); step();           // DELAY cycles 1..3
        #1;
        chk("mid_busy", busy_o, 1);
        chk("mid_idx", idx_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        delay_i = '0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_ready", ready_o, 0);
        step();
        #1;
        chk("mid_after_idx", idx_o, 0);
        chk("mid_after_ready", ready_o, 4'b0001);
        step();
        valid_i = '0;

`ifdef STREAM_DELAY_ARB_STATS_EN
        // Three handshakes on requester 1 only.
        do_reset();
        valid_i = 4'b0010; delay_i = '0; ready_i = 1'b1;
        repeat (3) begin step(); step(); end
        valid_i = '0;
        #1;
        for (int k = 0; k < NR; k++)
            chk("stats_cnt", xfer_cnt_o[k*16 +: 16], (k == 1) ? 3 : 0);
`endif

        // NumReq=1: every grant is index 0.
        v1 = 1'b1; d1 = 4'd2; ri1 = 1'b1; p1 = 32'h1234_5678;
        #1;
        chk("one_idle_valid", vo1, 0);
        step(); step();
        #1;
        chk("one_dly_valid", vo1, 0);
        step();
        #1;
        chk("one_valid", vo1, 1);
        chk("one_idx", i1, 0);
        chk("one_pay", po1, 32'h1234_5678);
        chk("one_ready", r1o, 1);
        step();
        v1 = 1'b0;
        #1;
        chk("one_busy", b1, 0);

        // Randomized run against the transaction-level model.
        do_reset();
        for (int k = 0; k < NR; k++) begin pend[k] = 1'b0; pay_q[k] = '0; end
        m_busy = 0; m_wait = 0; m_gidx = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
                    pend[k]  = 1'b1;
                    pay_q[k] = $urandom;
                end
                valid_i[k]            = pend[k];
                payload_i[k*DW +: DW] = pay_q[k];
            end
            delay_i = ($urandom_range(0, 7) == 0) ? LW'(15) : LW'($urandom_range(0, 3));
            ready_i = 1'($urandom_range(0, 1));
            #1;
            begin
                bit e_valid;
                e_valid = m_busy && (m_wait == 0);
                chk("rnd_valid", valid_o, e_valid);
                chk("rnd_busy", busy_o, m_busy);
                chk("rnd_ready", ready_o, (e_valid && ready_i) ? (64'(1) << m_gidx) : 0);
                if (e_valid) begin
                    chk("rnd_idx", idx_o, m_gidx);
                    chk("rnd_pay", payload_o, pay_q[m_gidx]);
                end
                if (!m_busy) begin
                    if (valid_i != '0) begin
                        bit found;
                        found = 0;
                        for (int off = 0; off < NR; off++) begin
                            int j;
                            j = (m_ptr + off) % NR;
                            if (!found && valid_i[j]) begin
                                found  = 1;
                                m_gidx = j;
                            end
                        end
                        m_wait = int'(delay_i);
                        m_busy = 1;
                    end
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (ready_i) begin
                    m_ptr        = (m_gidx + 1) % NR;
                    m_busy       = 0;
                    pend[m_gidx] = 1'b0;
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_delay_arbiter.md
Name: stream_delay_arbiter

Overview:
Shares one delayed output stream between NumReq requester streams. Round-robin picks a requester, waits a per-transaction programmable number of cycles, then presents that requester's payload downstream until handshake. Used in testbench and verification infrastructure to serialise several masters onto one port with controlled latency or throttling.

Parameters:
NumReq, 4, number of requester streams (>=1)
DataWidth, 32, payload width per requester
DelayWidth, 4, width of delay_i and the internal countdown
IdxWidth, (NumReq>1 ? $clog2(NumReq) : 1), width of idx_o (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
valid_i  in  NumReq  per-requester valid
ready_o  out  NumReq  per-requester ready (one-hot or zero)
payload_i  in  NumReq*DataWidth  packed payloads, requester k at [k*DataWidth +: DataWidth]
delay_i  in  DelayWidth  delay for the next grant, sampled at grant
valid_o  out  1  downstream valid
ready_i  in  1  downstream ready
payload_o  out  DataWidth  payload of the granted requester
idx_o  out  IdxWidth  index of the granted requester
busy_o  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, DELAY, SEND (registered state, 2 bits).
- Reset (rst_i high at a clk_i edge): state=IDLE, rr_ptr=0, grant_idx=0, count=0. All outputs 0 while in IDLE with no grant: valid_o=0, ready_o=0, busy_o=0, idx_o=0.
- IDLE: if |valid_i, pick the first requester with valid set, searching from rr_ptr upward and wrapping past NumReq-1. Register grant_idx and count=delay_i. Next state is DELAY if delay_i!=0, otherwise SEND. No ready_o is asserted in IDLE.
- DELAY: count decrements by 1 each cycle. On the cycle count==1, next state is SEND. A delay of D therefore spends exactly D cycles in DELAY.
- SEND: valid_o=1, payload_o=payload_i[grant_idx], ready_o[grant_idx]=ready_i, all other ready_o=0. On ready_i=1 the handshake completes: rr_ptr=(grant_idx+1) wrapped modulo NumReq, next state is IDLE.
- Latency: first valid_o comes 1+D cycles after the IDLE cycle in which the request is seen. Back-to-back throughput is at most one transfer per 2+D cycles.
- idx_o=grant_idx and payload_o are driven in all states; both are only meaningful while valid_o=1.
- Stream rules: a requester must hold valid_i and payload_i stable until it receives ready_o. A simulation assertion flags a granted requester that drops valid_i before its handshake. Requests not selected stay pending and are never dropped.
- Fairness: any continuously asserting requester is served within NumReq grants.
- Boundaries:
  - rr_ptr wraps from NumReq-1 to 0.
  - NumReq=1: always index 0.
  - delay_i at its maximum value (2^DelayWidth-1) is held without overflow.
  - delay_i changing during DELAY or SEND has no effect.
  - ready_i held high before SEND has no effect.
  - Reset asserted in DELAY or SEND aborts the transfer: no handshake is issued and rr_ptr returns to 0.

Optional Feature:
Macro: STREAM_DELAY_ARB_STATS_EN
- Defined: adds output xfer_cnt_o of width NumReq*16. Each requester's 16-bit counter increments on that requester's handshake, saturates at 0xFFFF, and clears on reset.
- Not defined: the port and the counters are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_delay_arb_pkg holds the state_e enum (IDLE=2'd0, DELAY=2'd1, SEND=2'd2) and the helper function clog2_min1.
- One combinational sub-module, stream_delay_arb_rr_pick. Inputs: req vector and pointer. Outputs: any_o and idx_o, the first set request at or after the pointer, with wrap.
- FSM, countdown and rr_ptr live in the top module.

Test Plan:
- Single request, no delay. NumReq=4, delay_i=0, valid_i=4'b0100 with payload 0xA5, ready_i=1. Required: valid_o rises 1 cycle later with idx_o=2 and payload_o=0xA5; ready_o=4'b0100 on that cycle; busy_o returns to 0 next cycle.
- Fixed delay. delay_i=3, valid_i=4'b0001, ready_i=1. Required: valid_o rises exactly 4 cycles after the request is seen, and stays low during the 3 DELAY cycles.
- Round-robin order. All 4 requesters valid, delay_i=0, ready_i=1, rr_ptr starting at 0. Required: grants in order 0,1,2,3,0, with one transfer every 2 cycles.
- Backpressure. In SEND, hold ready_i=0 for 5 cycles. Required: valid_o, idx_o and payload_o stable; ready_o all zero. Handshake happens on the cycle ready_i=1.
- Reset mid-transfer. delay_i=7; assert rst_i during the 3rd DELAY cycle. Required: next cycle state=IDLE, valid_o=0, ready_o=0; after reset, requester 0 is considered first.
- STATS_EN build. Complete 3 transfers on requester 1. Required: xfer_cnt_o for requester 1 reads 3 and all other counters read 0.
